// File: rtl/id_ex_operand_stage_if.sv
// ID-to-EX bundle: decoded instruction from ID, MEM/WB writeback taps, and the
// operands/control presented to the ALU. master drives ID side, slave is the stage.
interface id_ex_operand_stage_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [REGW-1:0] id_rs1;
  logic [REGW-1:0] id_rs2;
  logic [REGW-1:0] id_rd;
  logic [2:0]      id_alu_op;
  logic            id_asel;
  logic            id_bsel;
  logic            id_rf_we;
  logic            id_is_load;
  logic            id_uses_rs1;
  logic            id_uses_rs2;
  logic            stall;
  logic            flush;
  logic            mem_rf_we;
  logic [REGW-1:0] mem_rd;
  logic [XLEN-1:0] mem_wd;
  logic            wb_rf_we;
  logic [REGW-1:0] wb_rd;
  logic [XLEN-1:0] wb_wd;
  logic            load_use;
  logic            ex_valid;
  logic [XLEN-1:0] ex_A;
  logic [XLEN-1:0] ex_B;
  logic [2:0]      ex_alu_op;
  logic [XLEN-1:0] ex_store_data;
  logic [REGW-1:0] ex_rd;
  logic            ex_rf_we;
  logic            ex_is_load;
  logic [XLEN-1:0] ex_pc;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_op, id_asel, id_bsel, id_rf_we, id_is_load, id_uses_rs1, id_uses_rs2,
           stall, flush, mem_rf_we, mem_rd, mem_wd, wb_rf_we, wb_rd, wb_wd,
    input  load_use, ex_valid, ex_A, ex_B, ex_alu_op, ex_store_data, ex_rd, ex_rf_we,
           ex_is_load, ex_pc
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_op, id_asel, id_bsel, id_rf_we, id_is_load, id_uses_rs1, id_uses_rs2,
           stall, flush, mem_rf_we, mem_rd, mem_wd, wb_rf_we, wb_rd, wb_wd,
    output load_use, ex_valid, ex_A, ex_B, ex_alu_op, ex_store_data, ex_rd, ex_rf_we,
           ex_is_load, ex_pc
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use bubbling, capture-time WB bypass and
// combinational MEM/WB forwarding in front of the ALU.
module id_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input logic                  cpu_clk,
  input logic                  cpu_rst,
  id_ex_operand_stage_if.slave bus
);
  localparam int NSRC = 2;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1v;
    logic [XLEN-1:0] rs2v;
    logic [XLEN-1:0] imm;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic [2:0]      alu_op;
    logic            asel;
    logic            bsel;
    logic            rf_we;
    logic            is_load;
  } ex_slot_t;

  ex_slot_t ex, cap;
  logic     load_use;

  logic [NSRC-1:0][REGW-1:0] src;
  logic [NSRC-1:0][XLEN-1:0] held;
  logic [NSRC-1:0][XLEN-1:0] fwd;

  // Only a valid load with a real destination can stall a dependent reader.
  assign load_use = ex.valid & ex.is_load & (ex.rd != '0) & bus.id_valid &
                    ((bus.id_uses_rs1 & (bus.id_rs1 == ex.rd)) |
                     (bus.id_uses_rs2 & (bus.id_rs2 == ex.rd)));

  always_comb begin
    cap         = '0;
    cap.valid   = bus.id_valid;
    cap.pc      = bus.id_pc;
    cap.imm     = bus.id_imm;
    cap.rs1     = bus.id_rs1;
    cap.rs2     = bus.id_rs2;
    cap.rd      = bus.id_rd;
    cap.alu_op  = bus.id_alu_op;
    cap.asel    = bus.id_asel;
    cap.bsel    = bus.id_bsel;
    cap.rf_we   = bus.id_rf_we & bus.id_valid;
    cap.is_load = bus.id_is_load & bus.id_valid;
    // Regfile write and read land on the same edge; take the value being written.
    cap.rs1v    = (bus.wb_rf_we && bus.wb_rd != '0 && bus.wb_rd == bus.id_rs1) ?
                  bus.wb_wd : bus.id_rs1_data;
    cap.rs2v    = (bus.wb_rf_we && bus.wb_rd != '0 && bus.wb_rd == bus.id_rs2) ?
                  bus.wb_wd : bus.id_rs2_data;
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst)        ex <= '0;
    else if (bus.flush) ex <= '0;
    else if (!bus.stall) begin
      if (load_use) ex <= '0;
      else          ex <= cap;
    end
  end

  assign src[0]  = ex.rs1;
  assign src[1]  = ex.rs2;
  assign held[0] = ex.rs1v;
  assign held[1] = ex.rs2v;

  // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
  for (genvar g = 0; g < NSRC; g++) begin : g_fwd
    assign fwd[g] = (bus.mem_rf_we && bus.mem_rd != '0 && bus.mem_rd == src[g]) ? bus.mem_wd :
                    (bus.wb_rf_we  && bus.wb_rd  != '0 && bus.wb_rd  == src[g]) ? bus.wb_wd  :
                    held[g];
  end

  assign bus.load_use      = load_use;
  assign bus.ex_valid      = ex.valid;
  assign bus.ex_A          = ex.asel ? ex.pc  : fwd[0];
  assign bus.ex_B          = ex.bsel ? ex.imm : fwd[1];
  assign bus.ex_alu_op     = ex.alu_op;
  assign bus.ex_store_data = fwd[1];
  assign bus.ex_rd         = ex.rd;
  assign bus.ex_rf_we      = ex.rf_we;
  assign bus.ex_is_load    = ex.is_load;
  assign bus.ex_pc         = ex.pc;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench: each driven cycle pushes the predicted EX view, a negedge
// monitor pops and compares; directed plan sequences followed by random traffic.
module tb_id_ex_operand_stage;
  localparam int XLEN = 32;
  localparam int REGW = 5;

  logic cpu_clk = 1'b0;
  logic cpu_rst;
  always #5 cpu_clk = ~cpu_clk;

  id_ex_operand_stage_if #(.XLEN(XLEN), .REGW(REGW)) bus ();
  id_ex_operand_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .bus(bus)
  );

  // What the instruction in EX is, as the reference sees it.
  typedef struct {
    bit        v;
    bit [31:0] pc, a_val, b_val, imm;
    bit [4:0]  rs1, rs2, rd;
    bit [2:0]  op;
    bit        asel, bsel, we, ld;
  } instr_t;

  typedef struct packed {
    bit        lu, v;
    bit [31:0] a, b, sd, pc;
    bit [4:0]  rd;
    bit [2:0]  op;
    bit        we, ld;
  } obs_t;

  obs_t   exp_q[$];
  instr_t slot;
  int     total = 0;
  int     bad = 0;

  function automatic bit [31:0] operand(bit [4:0] r, bit [31:0] held_v);
    if (r == 0) return held_v;
    if (bus.mem_rf_we && bus.mem_rd == r) return bus.mem_wd;
    if (bus.wb_rf_we && bus.wb_rd == r) return bus.wb_wd;
    return held_v;
  endfunction

  function automatic bit reads_reg(bit [4:0] r, bit [31:0] d, output bit [31:0] v);
    v = (bus.wb_rf_we && r != 0 && bus.wb_rd == r) ? bus.wb_wd : d;
    return 1'b1;
  endfunction

  function automatic bit hazard();
    return slot.v && slot.ld && slot.rd != 0 && bus.id_valid &&
           ((bus.id_uses_rs1 && bus.id_rs1 == slot.rd) ||
            (bus.id_uses_rs2 && bus.id_rs2 == slot.rd));
  endfunction

  function automatic obs_t predict();
    obs_t o;
    bit [31:0] r1, r2;
    r1 = operand(slot.rs1, slot.a_val);
    r2 = operand(slot.rs2, slot.b_val);
    o.lu = hazard();
    o.v  = slot.v;
    o.a  = slot.asel ? slot.pc : r1;
    o.b  = slot.bsel ? slot.imm : r2;
    o.sd = r2;
    o.pc = slot.pc;
    o.rd = slot.rd;
    o.op = slot.op;
    o.we = slot.we;
    o.ld = slot.ld;
    return o;
  endfunction

  task automatic advance();
    instr_t n;
    bit     ok;
    n = '{default: 0};
    if (cpu_rst || bus.flush) n = '{default: 0};
    else if (bus.stall) n = slot;
    else if (!hazard()) begin
      n.v    = bus.id_valid;
      n.pc   = bus.id_pc;
      n.imm  = bus.id_imm;
      n.rs1  = bus.id_rs1;
      n.rs2  = bus.id_rs2;
      n.rd   = bus.id_rd;
      n.op   = bus.id_alu_op;
      n.asel = bus.id_asel;
      n.bsel = bus.id_bsel;
      n.we   = bus.id_rf_we && bus.id_valid;
      n.ld   = bus.id_is_load && bus.id_valid;
      ok = reads_reg(bus.id_rs1, bus.id_rs1_data, n.a_val);
      ok = reads_reg(bus.id_rs2, bus.id_rs2_data, n.b_val);
    end
    slot = n;
  endtask

  task automatic cycle();
    exp_q.push_back(predict());
    @(posedge cpu_clk);
    advance();
    #1;
  endtask

  task automatic chk(input string nm, input bit [31:0] act, input bit [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, expv);
    end
  endtask

  task automatic set_id(input bit v, input bit [31:0] pc, r1d, r2d, imm,
                        input bit [4:0] rs1, rs2, rd, input bit [2:0] op,
                        input bit asel, bsel, we, ld, u1, u2);
    bus.id_valid = v;     bus.id_pc = pc;        bus.id_rs1_data = r1d;
    bus.id_rs2_data = r2d; bus.id_imm = imm;     bus.id_rs1 = rs1;
    bus.id_rs2 = rs2;     bus.id_rd = rd;        bus.id_alu_op = op;
    bus.id_asel = asel;   bus.id_bsel = bsel;    bus.id_rf_we = we;
    bus.id_is_load = ld;  bus.id_uses_rs1 = u1;  bus.id_uses_rs2 = u2;
  endtask

  task automatic quiet();
    bus.stall = 0; bus.flush = 0;
    bus.mem_rf_we = 0; bus.mem_rd = 0; bus.mem_wd = 0;
    bus.wb_rf_we = 0;  bus.wb_rd = 0;  bus.wb_wd = 0;
  endtask

  always @(negedge cpu_clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.lu = bus.load_use;  a.v = bus.ex_valid;    a.a = bus.ex_A;
      a.b = bus.ex_B;       a.sd = bus.ex_store_data; a.pc = bus.ex_pc;
      a.rd = bus.ex_rd;     a.op = bus.ex_alu_op;  a.we = bus.ex_rf_we;
      a.ld = bus.ex_is_load;
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL sb t=%0t: got lu=%b v=%b A=%h B=%h sd=%h pc=%h rd=%0d op=%0d we=%b ld=%b want lu=%b v=%b A=%h B=%h sd=%h pc=%h rd=%0d op=%0d we=%b ld=%b",
                 $time, a.lu, a.v, a.a, a.b, a.sd, a.pc, a.rd, a.op, a.we, a.ld,
                 e.lu, e.v, e.a, e.b, e.sd, e.pc, e.rd, e.op, e.we, e.ld);
      end
    end
  end

  initial begin
    bit [31:0] pc_hold, a_hold;
    cpu_rst = 1;
    quiet();
    set_id(1, 32'h40, 1, 2, 3, 1, 2, 3, 0, 0, 0, 1, 1, 1, 1);
    slot = '{default: 0};
    @(posedge cpu_clk); #1;

    // reset with a valid ID instruction waiting
    cycle();
    chk("rst_valid", bus.ex_valid, 0);
    chk("rst_we", bus.ex_rf_we, 0);
    chk("rst_A", bus.ex_A, 0);
    chk("rst_B", bus.ex_B, 0);
    cycle();
    cpu_rst = 0;

    // add x3,x1,x2 then sub x4,x3,x1 with x3 forwarded from MEM
    set_id(1, 32'h100, 5, 7, 0, 1, 2, 3, 3'b000, 0, 0, 1, 0, 1, 1);
    cycle();
    chk("cap_valid", bus.ex_valid, 1);
    chk("add_A", bus.ex_A, 5);
    set_id(1, 32'h104, 0, 5, 0, 3, 1, 4, 3'b001, 0, 0, 1, 0, 1, 1);
    bus.mem_rf_we = 1; bus.mem_rd = 3; bus.mem_wd = 12;
    cycle();
    chk("sub_A", bus.ex_A, 12);
    chk("sub_B", bus.ex_B, 5);
    chk("sub_op", bus.ex_alu_op, 3'b001);

    // MEM beats WB, WB alone, and x0 never forwarded
    set_id(1, 32'h108, 55, 0, 0, 3, 0, 7, 3'b010, 0, 0, 1, 0, 1, 0);
    bus.wb_rf_we = 1; bus.wb_rd = 3; bus.wb_wd = 99;
    cycle();
    chk("dbl_mem", bus.ex_A, 12);
    bus.mem_rf_we = 0; #1;
    chk("dbl_wb", bus.ex_A, 99);
    set_id(1, 32'h10c, 0, 0, 0, 0, 0, 7, 3'b011, 0, 0, 1, 0, 1, 0);
    bus.mem_rf_we = 1; bus.mem_rd = 0; bus.wb_rd = 0;
    cycle();
    chk("x0_A", bus.ex_A, 0);
    quiet();

    // lw x5 ; add x6,x5,x5 -> one bubble, then value from WB
    set_id(1, 32'h200, 32'h1000, 0, 4, 1, 0, 5, 3'b000, 0, 1, 1, 1, 1, 0);
    cycle();
    set_id(1, 32'h204, 0, 0, 0, 5, 5, 6, 3'b000, 0, 0, 1, 0, 1, 1);
    #1;
    chk("lu_hi", bus.load_use, 1);
    cycle();
    chk("lu_bubble", bus.ex_valid, 0);
    bus.wb_rf_we = 1; bus.wb_rd = 5; bus.wb_wd = 32'hDEADBEEF;
    #1;
    chk("lu_lo", bus.load_use, 0);
    cycle();
    bus.wb_rf_we = 0; #1;
    chk("lu_A", bus.ex_A, 32'hDEADBEEF);
    chk("lu_B", bus.ex_B, 32'hDEADBEEF);
    quiet();

    // stall freezes EX; flush with stall still clears it
    set_id(1, 32'h300, 9, 8, 0, 1, 2, 9, 3'b100, 0, 0, 1, 0, 1, 1);
    cycle();
    pc_hold = bus.ex_pc; a_hold = bus.ex_A;
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 32'h400 + i * 4, i, i, i, 4, 4, 10, 3'b101, 0, 0, 1, 0, 1, 1);
      cycle();
      chk("stall_pc", bus.ex_pc, pc_hold);
      chk("stall_A", bus.ex_A, a_hold);
    end
    bus.flush = 1;
    cycle();
    chk("flush_v", bus.ex_valid, 0);
    chk("flush_we", bus.ex_rf_we, 0);
    quiet();

    // auipc-style operand select; store data still follows rs2
    set_id(1, 32'h1000, 32'h11, 32'h22, 32'h2000, 1, 2, 8, 3'b000, 1, 1, 1, 0, 0, 0);
    cycle();
    chk("pc_A", bus.ex_A, 32'h1000);
    chk("imm_B", bus.ex_B, 32'h2000);
    chk("sd_held", bus.ex_store_data, 32'h22);
    bus.mem_rf_we = 1; bus.mem_rd = 2; bus.mem_wd = 32'h77; #1;
    chk("sd_fwd", bus.ex_store_data, 32'h77);
    quiet();

    // random traffic on a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      cpu_rst = ($urandom_range(0, 49) == 0);
      set_id($urandom_range(0, 4) != 0, $urandom, $urandom, $urandom, $urandom,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom));
      bus.stall     = ($urandom_range(0, 4) == 0);
      bus.flush     = ($urandom_range(0, 9) == 0);
      bus.mem_rf_we = 1'($urandom);
      bus.mem_rd    = 5'($urandom_range(0, 3));
      bus.mem_wd    = $urandom;
      bus.wb_rf_we  = 1'($urandom);
      bus.wb_rd     = 5'($urandom_range(0, 3));
      bus.wb_wd     = $urandom;
      cycle();
    end

    #10;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
